// File: rtl/sync_pkg.sv
// Shared types and helpers for the sync word framer.
package sync_pkg;

  localparam int SYNC_W_DEF = 32;

  typedef enum logic {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } framer_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } byte_beat_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Small register FIFO of payload beats; the read side is the AXI4-Stream master.
module sync_byte_fifo
  import sync_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_push,
  input  byte_beat_t i_beat,
  output logic       o_full,
  output logic       o_empty,
  input  logic       i_ready,
  output logic       o_pop,
  output byte_beat_t o_beat
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  byte_beat_t  r_mem [FIFO_DEPTH];
  logic        w_wr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_pop   = !o_empty && i_ready;
  // A pop frees the slot this same edge, so a push into a full FIFO may proceed.
  assign w_wr    = i_push && (!o_full || o_pop);
  assign o_beat  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_beat;
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (o_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sync_word_framer.sv
// Hamming-tolerant sync word search followed by MSB-first byte packing onto AXI4-Stream.
// Optional SYNC_INVERT_DETECT_EN: also accept the inverted word and invert that frame's payload.
module sync_word_framer
  import sync_pkg::*;
#(
  parameter int SYNC_W     = SYNC_W_DEF,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic [SYNC_W-1:0] cfg_sync_word,
  input  logic [SYNC_W-1:0] cfg_sync_mask,
  input  logic [5:0]        cfg_threshold,
  input  logic [LEN_W-1:0]  cfg_frame_len,
  input  logic              cfg_ovf_clr,
  input  logic              s_bit,
  input  logic              s_bit_valid,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              sync_found,
  output logic [LEN_W-1:0]  frame_cnt,
  output logic              overflow,
  output logic              locked
`ifdef SYNC_INVERT_DETECT_EN
  ,
  output logic              sync_inverted
`endif
);

  localparam int BS_W = $clog2(SYNC_W + 1);

  framer_state_e     r_state, w_state_nxt;
  logic [SYNC_W-1:0] r_shreg;
  logic [BS_W-1:0]   r_bits_seen;
  logic              r_shifted_q;
  logic [7:0]        r_byte;
  logic [2:0]        r_bit_cnt;
  logic [LEN_W-1:0]  r_byte_cnt;
  logic [LEN_W-1:0]  r_len_q;
  logic [LEN_W-1:0]  r_frame_cnt;
  logic              r_overflow;

  logic [5:0]        w_dist;
  logic              w_dist_ok;
  logic              w_inv_ok;
  logic              w_cand;
  logic              w_detect;
  logic              w_det_inv;
  logic              w_pay_inv;
  logic              w_bit;
  logic [7:0]        w_byte_nxt;
  logic              w_shift;
  logic              w_take_bit;
  logic              w_push;
  logic              w_last;
  logic              w_clear_search;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_fifo_pop;
  logic              w_drop;
  byte_beat_t        w_beat_in;
  byte_beat_t        w_beat_out;

  assign w_dist    = popcount32(32'((r_shreg ^ cfg_sync_word) & cfg_sync_mask));
  assign w_dist_ok = (w_dist <= cfg_threshold);

`ifdef SYNC_INVERT_DETECT_EN
  logic       r_inv_q;
  logic [5:0] w_dist_inv;
  assign w_dist_inv    = popcount32(32'((r_shreg ^ ~cfg_sync_word) & cfg_sync_mask));
  assign w_inv_ok      = (w_dist_inv <= cfg_threshold);
  assign w_det_inv     = !w_dist_ok;
  assign w_pay_inv     = w_detect ? w_det_inv : r_inv_q;
  assign sync_inverted = w_pay_inv;
`else
  assign w_inv_ok  = 1'b0;
  assign w_det_inv = 1'b0;
  assign w_pay_inv = 1'b0;
`endif

  // dist is only meaningful on a full window that was updated on the previous edge.
  assign w_cand     = (r_state == SEARCH) && cfg_enable && r_shifted_q &&
                      (r_bits_seen == BS_W'(SYNC_W));
  assign w_detect   = w_cand && (w_dist_ok || w_inv_ok);
  assign w_bit      = s_bit ^ w_pay_inv;
  assign w_byte_nxt = {r_byte[6:0], w_bit};

  always_comb begin
    w_state_nxt    = r_state;
    w_shift        = 1'b0;
    w_take_bit     = 1'b0;
    w_push         = 1'b0;
    w_last         = 1'b0;
    w_clear_search = 1'b0;
    if (!cfg_enable) begin
      w_state_nxt    = SEARCH;
      w_clear_search = 1'b1;
    end else begin
      case (r_state)
        SEARCH: begin
          if (w_detect) begin
            if (cfg_frame_len == '0) begin
              w_clear_search = 1'b1;
            end else begin
              w_state_nxt = PAYLOAD;
              w_take_bit  = s_bit_valid;
            end
          end else begin
            w_shift = s_bit_valid;
          end
        end
        PAYLOAD: begin
          if (s_bit_valid) begin
            w_take_bit = 1'b1;
            if (r_bit_cnt == 3'd7) begin
              w_push = 1'b1;
              w_last = (r_byte_cnt == r_len_q - LEN_W'(1));
              if (w_last) begin
                w_state_nxt    = SEARCH;
                w_clear_search = 1'b1;
              end
            end
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_shreg     <= '0;
      r_bits_seen <= '0;
      r_shifted_q <= 1'b0;
      r_byte      <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_len_q     <= '0;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
`ifdef SYNC_INVERT_DETECT_EN
      r_inv_q     <= 1'b0;
`endif
    end else begin
      r_shifted_q <= w_shift;
      if (w_shift) begin
        r_shreg <= {r_shreg[SYNC_W-2:0], s_bit};
        if (r_bits_seen != BS_W'(SYNC_W)) begin
          r_bits_seen <= r_bits_seen + BS_W'(1);
        end
      end
      if (w_take_bit) begin
        r_byte    <= w_byte_nxt;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_push) begin
        r_byte_cnt <= r_byte_cnt + LEN_W'(1);
      end
      if (w_detect) begin
        r_frame_cnt <= r_frame_cnt + LEN_W'(1);
        r_len_q     <= cfg_frame_len;
        r_byte_cnt  <= '0;
        r_bit_cnt   <= w_take_bit ? 3'd1 : 3'd0;
`ifdef SYNC_INVERT_DETECT_EN
        r_inv_q     <= w_det_inv;
`endif
      end
      // Leaving the frame (or disabling) forces a fresh 32-bit window before the next match.
      if (w_clear_search) begin
        r_shreg     <= '0;
        r_bits_seen <= '0;
        r_byte      <= '0;
        r_bit_cnt   <= '0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (cfg_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign w_beat_in.data = w_byte_nxt;
  assign w_beat_in.last = w_last;
  assign w_drop         = w_push && w_fifo_full && !w_fifo_pop;

  sync_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_beat  (w_beat_in),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .i_ready (m_axis_tready),
    .o_pop   (w_fifo_pop),
    .o_beat  (w_beat_out)
  );

  assign m_axis_tdata  = w_beat_out.data;
  assign m_axis_tlast  = w_beat_out.last;
  assign m_axis_tvalid = !w_fifo_empty;
  assign sync_found    = w_detect;
  assign frame_cnt     = r_frame_cnt;
  assign overflow      = r_overflow;
  assign locked        = (r_state == PAYLOAD);

endmodule

// File: tb/tb_sync_word_framer.sv
// Directed bench for sync_word_framer; define SYNC_INVERT_DETECT_EN to add the inverted-match case.
module tb_sync_word_framer;

  localparam logic [31:0] ASM = 32'h1ACFFC1D;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_enable = 1'b1;
  logic [31:0] cfg_sync_word = ASM;
  logic [31:0] cfg_sync_mask = 32'hFFFFFFFF;
  logic [5:0]  cfg_threshold = 6'd0;
  logic [15:0] cfg_frame_len = 16'd2;
  logic        cfg_ovf_clr = 1'b0;
  logic        s_bit = 1'b0;
  logic        s_bit_valid = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        sync_found;
  logic [15:0] frame_cnt;
  logic        overflow;
  logic        locked;
`ifdef SYNC_INVERT_DETECT_EN
  logic        sync_inverted;
`endif

  int          n_total = 0;
  int          n_bad = 0;
  int          n_sync = 0;
  logic [8:0]  q_beats [$];

  sync_word_framer dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_enable    (cfg_enable),
    .cfg_sync_word (cfg_sync_word),
    .cfg_sync_mask (cfg_sync_mask),
    .cfg_threshold (cfg_threshold),
    .cfg_frame_len (cfg_frame_len),
    .cfg_ovf_clr   (cfg_ovf_clr),
    .s_bit         (s_bit),
    .s_bit_valid   (s_bit_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sync_found    (sync_found),
    .frame_cnt     (frame_cnt),
    .overflow      (overflow),
    .locked        (locked)
`ifdef SYNC_INVERT_DETECT_EN
    ,
    .sync_inverted (sync_inverted)
`endif
  );

  always #5 clock = ~clock;

  // Inputs only change 1 time unit after posedge, so negedge state is what the next edge sees.
  always @(negedge clock) begin
    if (!reset) begin
      if (sync_found) n_sync++;
      if (m_axis_tvalid && m_axis_tready) q_beats.push_back({m_axis_tlast, m_axis_tdata});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [7:0] data, input logic last);
    if (idx < q_beats.size()) chk(tag, 32'(q_beats[idx]), {23'b0, last, data});
    else chk({tag, "_missing"}, q_beats.size(), idx + 1);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      s_bit       = v[i];
      s_bit_valid = 1'b1;
      @(posedge clock);
      #1;
    end
    s_bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  int sb, bb;

  initial begin
    idle(1);
    do_reset();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_sync", sync_found, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_locked", locked, 0);

    // ASM match, two-byte frame
    sb = n_sync; bb = q_beats.size();
    send_bits(ASM, 32);
    chk("asm_sync_lat", sync_found, 1);
`ifdef SYNC_INVERT_DETECT_EN
    chk("asm_not_inv", sync_inverted, 0);
`endif
    send_bits(32'h1, 1);
    chk("asm_locked", locked, 1);
    send_bits(32'h25, 7);
    send_bits(32'h3C, 8);
    idle(4);
    chk("asm_nsync", n_sync - sb, 1);
    chk("asm_nbeats", q_beats.size() - bb, 2);
    chk_beat("asm_b0", bb, 8'hA5, 1'b0);
    chk_beat("asm_b1", bb + 1, 8'h3C, 1'b1);
    chk("asm_fcnt", frame_cnt, 1);
    chk("asm_unlocked", locked, 0);

    // Error tolerance with len=0 (detection without payload)
    cfg_threshold = 6'd2; cfg_frame_len = 16'd0;
    do_reset();
    sb = n_sync; bb = q_beats.size();
    send_bits(ASM ^ 32'h00010001, 32);
    chk("tol2_sync", sync_found, 1);
    idle(4);
    chk("len0_nbeats", q_beats.size() - bb, 0);
    chk("len0_fcnt", frame_cnt, 1);
    chk("len0_locked", locked, 0);
    do_reset();
    sb = n_sync;
    send_bits(ASM ^ 32'h80010001, 32);
    chk("tol3_sync", sync_found, 0);
    idle(3);
    chk("tol3_nsync", n_sync - sb, 0);
    cfg_threshold = 6'd0; cfg_sync_mask = 32'hFFFF0000;
    do_reset();
    send_bits(ASM ^ 32'h000000FF, 32);
    chk("mask_sync", sync_found, 1);
    cfg_sync_mask = 32'hFFFFFFFF;

    // Backpressure and overflow
    cfg_frame_len = 16'd4; m_axis_tready = 1'b0;
    do_reset();
    bb = q_beats.size();
    send_bits(ASM, 32);
    send_bits(32'h11223344, 32);
    idle(3);
    chk("bp_ovf", overflow, 1);
    chk("bp_tvalid", m_axis_tvalid, 1);
    chk("bp_tdata_hold", m_axis_tdata, 8'h11);
    chk("bp_tlast_hold", m_axis_tlast, 0);
    chk("bp_locked", locked, 0);
    cfg_ovf_clr = 1'b1;
    idle(1);
    cfg_ovf_clr = 1'b0;
    chk("bp_ovf_clr", overflow, 0);
    m_axis_tready = 1'b1;
    idle(4);
    chk("bp_nbeats", q_beats.size() - bb, 2);
    chk_beat("bp_b0", bb, 8'h11, 1'b0);
    chk_beat("bp_b1", bb + 1, 8'h22, 1'b0);
    chk("bp_drained", m_axis_tvalid, 0);

    // Back-to-back one-byte frames
    cfg_frame_len = 16'd1;
    do_reset();
    sb = n_sync; bb = q_beats.size();
    send_bits(ASM, 32);
    send_bits(32'h77, 8);
    send_bits(ASM, 32);
    send_bits(32'h88, 8);
    idle(4);
    chk("b2b_fcnt", frame_cnt, 2);
    chk("b2b_nsync", n_sync - sb, 2);
    chk_beat("b2b_b0", bb, 8'h77, 1'b1);
    chk_beat("b2b_b1", bb + 1, 8'h88, 1'b1);

    // Payload equal to the sync word must not re-trigger
    cfg_frame_len = 16'd4;
    do_reset();
    sb = n_sync; bb = q_beats.size();
    send_bits(ASM, 32);
    send_bits(ASM, 32);
    idle(4);
    chk("nofalse_nsync", n_sync - sb, 1);
    chk("nofalse_nbeats", q_beats.size() - bb, 4);
    chk_beat("nofalse_b0", bb, 8'h1A, 1'b0);
    chk_beat("nofalse_b3", bb + 3, 8'h1D, 1'b1);

    // Disable mid-payload
    cfg_frame_len = 16'd2;
    do_reset();
    sb = n_sync; bb = q_beats.size();
    send_bits(ASM, 32);
    send_bits(32'hA, 4);
    chk("dis_locked_pre", locked, 1);
    cfg_enable = 1'b0;
    idle(1);
    chk("dis_locked", locked, 0);
    send_bits(32'hFF, 8);
    idle(2);
    chk("dis_nbeats", q_beats.size() - bb, 0);
    cfg_enable = 1'b1;
    send_bits(ASM, 32);
    send_bits(32'hC396, 16);
    idle(4);
    chk("dis_nsync", n_sync - sb, 2);
    chk("dis_nbeats2", q_beats.size() - bb, 2);
    chk_beat("dis_b0", bb, 8'hC3, 1'b0);
    chk_beat("dis_b1", bb + 1, 8'h96, 1'b1);
    chk("dis_fcnt", frame_cnt, 2);

`ifdef SYNC_INVERT_DETECT_EN
    cfg_frame_len = 16'd1;
    do_reset();
    bb = q_beats.size();
    send_bits(~ASM, 32);
    chk("inv_sync", sync_found, 1);
    chk("inv_flag", sync_inverted, 1);
    send_bits(32'h5A, 8);
    chk("inv_held", sync_inverted, 1);
    idle(4);
    chk_beat("inv_b0", bb, 8'hA5, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
